debug_uart_tx: RTL
==================

Name: debug_uart_tx

Overview:
- 8N1 UART transmitter with an integrated baud-tick generator.
- Sits directly downstream of the debugger frame serializer: consumes its wr_uart/w_data byte stream and returns tx_busy for flow control.
- Drives the board TX pin that carries MIPS debug frames to the host PC.

Parameters:
- CLK_DIV, 163, system clocks per oversample tick (50 MHz / (19200 baud × 16)); legal range 2..65535.
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversample ticks per bit period, applied to every bit including start and stop.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_uart  in  1  byte-write strobe from the serializer.
- w_data  in  8  byte to transmit; valid while wr_uart=1.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is in flight; writes are refused while it is high.
- tx_done_tick  out  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset=0 at a clock edge):
  - tx=1, tx_busy=0, tx_done_tick=0.
  - FSM goes to IDLE; baud counter, tick counter, bit counter and shift register clear to 0.
  - Reset applied mid-frame aborts the frame; tx returns high on that same edge with no partial stop bit.
- Baud generator:
  - Counter runs 0..CLK_DIV-1; s_tick is high for one cycle when the count equals CLK_DIV-1.
  - The counter is forced to 0 on the cycle a write is accepted, so every bit lasts exactly SB_TICK×CLK_DIV clocks.
- Write acceptance:
  - A write is accepted on an edge where wr_uart=1 and tx_busy=0.
  - On that edge: w_data is latched into the shift register, the FSM enters START, tx becomes 0, and tx_busy becomes 1.
  - tx_busy is registered and is already high in the cycle after acceptance, so an upstream FSM that re-tests ~tx_busy cannot issue a double write.
- Refused writes: wr_uart while tx_busy=1 is ignored. There is no state change and no queuing.
- FSM states:
  - IDLE: tx=1. Leaves to START on an accepted write.
  - START: tx=0. Counts SB_TICK s_ticks, then goes to DATA with the bit counter at 0.
  - DATA: tx = shift register bit 0, so data goes out LSB first. Every SB_TICK s_ticks the register shifts right and the bit counter increments. After bit DBIT-1 the FSM goes to STOP.
  - STOP: tx=1. After SB_TICK s_ticks the FSM goes to IDLE. On that edge tx_busy falls to 0 and tx_done_tick is 1 for exactly one cycle.
- Frame timing:
  - Busy duration = (DBIT+2)×SB_TICK×CLK_DIV clocks.
  - The earliest next accepted write is in the same cycle tx_busy reads 0, so back-to-back frames have no idle gap.
  - A wr_uart asserted on the final STOP edge sees tx_busy=1 and is refused.
- Widths:
  - Tick counter is 4 bits.
  - Bit counter is ceil(log2(DBIT+1)) bits.
  - Baud counter is ceil(log2(CLK_DIV)) bits.
- Wrap-around: all counters wrap only under FSM control; none free-run past their terminal value while in IDLE, except the baud counter, which free-runs.

Optional Feature:
- Macro: DEBUG_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and drives the even parity (XOR) of the latched byte for SB_TICK ticks.
  - Busy duration becomes (DBIT+3)×SB_TICK×CLK_DIV clocks.
  - The host must be configured for 8E1.
- When undefined: there is no PARITY state and framing is 8N1 exactly as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles during an active frame → on the first reset edge tx=1 and tx_busy=0; no tx_done_tick ever follows.
- Single byte: CLK_DIV=4, write 0xA5 →
  - tx_busy rises the next cycle and stays high 640 cycles;
  - tx samples 64 cycles apart read 0,1,0,1,0,0,1,0,1,1;
  - tx_done_tick pulses once.
- Refused write: during the 0xA5 frame, pulse wr_uart with 0x3C at cycle 100 → waveform is unchanged from the single-byte case; no second frame follows.
- Back-to-back: drive the serializer model with a 3-byte burst 0x01, 0xFF, 0x80 → three contiguous 640-cycle frames with no idle bits between them, and exactly 3 tx_done_tick pulses.
- Mid-frame reset then resume: reset=0 during DATA bit 3, release, write 0x55 → a clean full 0x55 frame with 640-cycle busy duration.
- Parity (DEBUG_UART_TX_PARITY_EN defined): write 0x07 → the bit after the 8 data bits is 1; busy lasts 704 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/debug_uart_tx_if.sv
// debug_uart_tx_if
// Byte-stream handshake between the debugger frame serializer and the
// debug UART transmitter.
//   wr_uart      : byte-write strobe (serializer -> UART)
//   w_data[7:0]  : byte to send, valid while wr_uart=1 (serializer -> UART)
//   tx_busy      : frame in flight, writes refused (UART -> serializer)
//   tx_done_tick : one-cycle pulse at end of stop bit (UART -> serializer)
// Modports: master = serializer side, slave = UART side.
interface debug_uart_tx_if;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (
        output wr_uart,
        output w_data,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  wr_uart,
        input  w_data,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/debug_uart_tx.sv
// debug_uart_tx
// 8N1 UART transmitter with an integrated baud-tick generator. Carries MIPS
// debug frames from the frame serializer to the host PC.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low reset
//   bus    : debug_uart_tx_if.slave (wr_uart, w_data, tx_busy, tx_done_tick)
//   tx     : serial line, idle high
//
// Parameters:
//   CLK_DIV : system clocks per oversample tick (2..65535)
//   DBIT    : data bits per frame (at most 8)
//   SB_TICK : oversample ticks per bit period (at most 16, 4-bit counter)
//
// Optional build macro DEBUG_UART_TX_PARITY_EN: adds an even-parity bit
// between the data bits and the stop bit (8E1 framing).
//
// State table:
//   IDLE   | line high, waiting for a write
//   START  | start bit (low) for SB_TICK ticks
//   DATA   | shift register bit 0 on the line, LSB first, DBIT bits
//   PARITY | even parity of the latched byte (parity build only)
//   STOP   | stop bit (high) for SB_TICK ticks
module debug_uart_tx #(
    parameter int CLK_DIV = 163,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic               clk,
    input  logic               reset,
    debug_uart_tx_if.slave     bus,
    output logic               tx
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DBIT + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        TICK_LAST = 4'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBIT - 1);

`ifdef DEBUG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [3:0]        tick_cnt, tick_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [DBIT-1:0]   sreg, sreg_n;
    logic              tx_q, tx_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              s_tick;
    logic              accept;
`ifdef DEBUG_UART_TX_PARITY_EN
    // The shift register is consumed by the time the parity bit goes out,
    // so parity is captured at acceptance.
    logic              par_q, par_n;
`endif

    assign s_tick = (baud_cnt == BAUD_LAST);
    assign accept = bus.wr_uart && !busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            sreg     <= sreg_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sreg_n  = sreg;
        done_n  = 1'b0;
        baud_n  = s_tick ? '0 : baud_cnt + BAUD_W'(1);
`ifdef DEBUG_UART_TX_PARITY_EN
        par_n   = par_q;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    tick_n  = '0;
                    sreg_n  = bus.w_data[DBIT-1:0];
                    // Re-phase the baud counter so the start bit is a full period.
                    baud_n  = '0;
`ifdef DEBUG_UART_TX_PARITY_EN
                    par_n   = ^bus.w_data[DBIT-1:0];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_n = DATA;
                        tick_n  = '0;
                        bit_n   = '0;
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        sreg_n = sreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef DEBUG_UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
`ifdef DEBUG_UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_n = STOP;
                        tick_n  = '0;
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        state_n = IDLE;
                        tick_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level and busy are registered from the next state so they
        // change on the same edge as the FSM.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sreg_n[0];
`ifdef DEBUG_UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign tx               = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_done_tick = done_q;

endmodule
